// File: rtl/hack_debug_clk_ctrl.sv
// Debug clock-enable controller for the Hack computer: run, divide, single-step and burst modes.
// Optional PC breakpoint support is compiled in when HACK_DEBUG_BREAKPOINT_EN is defined.
module hack_debug_clk_ctrl #(
    parameter int unsigned DIV_W       = 24,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PC_W        = 15,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_CLK,
    input  logic             i_RESET_n,
    input  logic [1:0]       i_Mode,
    input  logic [DIV_W-1:0] i_Div,
    input  logic             i_Step,
    input  logic [CNT_W-1:0] i_Burst_Len,
    input  logic [PC_W-1:0]  i_PC,
    input  logic [PC_W-1:0]  i_Break_Addr,
    input  logic             i_Break_Valid,
    output logic             o_CLK_EN,
    output logic             o_Halted,
    output logic             o_Break_Hit,
    output logic [31:0]      o_Cycle_Cnt
);

    localparam int unsigned CYC_W = 32;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_DIV   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    state_t             state, state_next;
    logic               en, en_next;
    logic [DIV_W-1:0]   div_cnt, div_next;
    logic [CNT_W-1:0]   burst_cnt, burst_next;
    logic               skip, skip_next;
    logic               halted, halted_next;
    logic               break_hit, break_next;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [1:0]         mode_q;
    logic               mode_chg;
    logic               hit;

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev;
    logic                   step;

    // Button synchroniser and registered rising-edge pulse; a held button yields one pulse.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            sync      <= '0;
            sync_prev <= 1'b0;
            step      <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], i_Step};
            sync_prev <= sync[SYNC_STAGES-1];
            step      <= sync[SYNC_STAGES-1] & ~sync_prev;
        end
    end

    assign mode_chg = (i_Mode != mode_q);

`ifdef HACK_DEBUG_BREAKPOINT_EN
    // Same-cycle gate: the instruction at the breakpoint address is never executed on arrival.
    assign hit = i_Break_Valid && (i_PC == i_Break_Addr) && !skip &&
                 ((state == ST_RUN) || (state == ST_BURST));
`else
    logic unused_bp;
    assign hit       = 1'b0;
    assign unused_bp = ^{i_PC, i_Break_Addr, i_Break_Valid};
`endif

    assign o_CLK_EN = en & ~hit;

    always_comb begin
        state_next = state;
        en_next    = 1'b0;
        div_next   = div_cnt;
        burst_next = burst_cnt;
        skip_next  = skip & ~o_CLK_EN;

        if (mode_chg) begin
            // Any mode switch drops pending work and re-enters from IDLE.
            state_next = ST_IDLE;
            div_next   = '0;
            burst_next = '0;
            skip_next  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (i_Mode)
                        MODE_RUN, MODE_DIV: begin
                            state_next = ST_RUN;
                            div_next   = '0;
                        end
                        MODE_STEP: en_next = step;
                        MODE_BURST: begin
                            if (step && (i_Burst_Len != '0)) begin
                                state_next = ST_BURST;
                                burst_next = i_Burst_Len;
                            end
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
                ST_RUN: begin
                    if (hit) begin
                        state_next = ST_BREAK;
                    end else if (i_Mode == MODE_RUN) begin
                        en_next = 1'b1;
                    end else if (i_Mode == MODE_DIV) begin
                        if (div_cnt >= i_Div) begin
                            en_next  = 1'b1;
                            div_next = '0;
                        end else begin
                            div_next = div_cnt + DIV_W'(1);
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (hit) begin
                        // Give back the enable that was suppressed so the resume finishes the count.
                        state_next = ST_BREAK;
                        burst_next = burst_cnt + CNT_W'(en);
                    end else if (burst_cnt != '0) begin
                        en_next    = 1'b1;
                        burst_next = burst_cnt - CNT_W'(1);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (step) begin
                        state_next = (i_Mode == MODE_BURST) ? ST_BURST : ST_RUN;
                        skip_next  = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        halted_next = ((state_next == ST_IDLE) || (state_next == ST_BREAK)) && !en_next;
        break_next  = (state_next == ST_BREAK);
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state     <= ST_IDLE;
            en        <= 1'b0;
            div_cnt   <= '0;
            burst_cnt <= '0;
            skip      <= 1'b0;
            halted    <= 1'b1;
            break_hit <= 1'b0;
            mode_q    <= MODE_RUN;
        end else begin
            state     <= state_next;
            en        <= en_next;
            div_cnt   <= div_next;
            burst_cnt <= burst_next;
            skip      <= skip_next;
            halted    <= halted_next;
            break_hit <= break_next;
            mode_q    <= i_Mode;
        end
    end

    // Executed-cycle counter, wraps naturally.
    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            cyc_cnt <= '0;
        end else if (o_CLK_EN) begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
    end

    assign o_Halted    = halted;
    assign o_Break_Hit = break_hit;
    assign o_Cycle_Cnt = cyc_cnt;

endmodule

// File: tb/tb_hack_debug_clk_ctrl.sv
// Directed testbench for hack_debug_clk_ctrl: run, divide, step, burst, reset and breakpoint behaviour.
module tb_hack_debug_clk_ctrl;

    localparam int unsigned DIV_W = 24;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned PC_W  = 15;
    localparam int unsigned SYNC  = 2;

    localparam logic [1:0] M_RUN   = 2'b00;
    localparam logic [1:0] M_DIV   = 2'b01;
    localparam logic [1:0] M_STEP  = 2'b10;
    localparam logic [1:0] M_BURST = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       i_Mode;
    logic [DIV_W-1:0] i_Div;
    logic             i_Step;
    logic [CNT_W-1:0] i_Burst_Len;
    logic [PC_W-1:0]  i_PC;
    logic [PC_W-1:0]  i_Break_Addr;
    logic             i_Break_Valid;
    logic             o_CLK_EN;
    logic             o_Halted;
    logic             o_Break_Hit;
    logic [31:0]      o_Cycle_Cnt;

    int tests = 0;
    int fails = 0;
    bit pc_track = 1'b0;

    always #5 clk = ~clk;

    hack_debug_clk_ctrl #(
        .DIV_W(DIV_W), .CNT_W(CNT_W), .PC_W(PC_W), .SYNC_STAGES(SYNC)
    ) dut (
        .i_CLK(clk), .i_RESET_n(rst_n), .i_Mode(i_Mode), .i_Div(i_Div), .i_Step(i_Step),
        .i_Burst_Len(i_Burst_Len), .i_PC(i_PC), .i_Break_Addr(i_Break_Addr),
        .i_Break_Valid(i_Break_Valid), .o_CLK_EN(o_CLK_EN), .o_Halted(o_Halted),
        .o_Break_Hit(o_Break_Hit), .o_Cycle_Cnt(o_Cycle_Cnt)
    );

    // Advance one clock from a negedge to the next; emulates a CPU whose PC advances on enabled edges.
    task automatic next_cycle();
        logic en_prev;
        #4;
        en_prev = o_CLK_EN;
        @(posedge clk);
        #1;
        if (pc_track && en_prev) i_PC = i_PC + PC_W'(1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_Mode = M_RUN; i_Div = '0; i_Step = 1'b0; i_Burst_Len = '0;
        i_PC = '0; i_Break_Addr = PC_W'(7); i_Break_Valid = 1'b0; pc_track = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (o_CLK_EN !== 1'b0) begin fails++; $display("FAIL reset_en: got %b expected 0", o_CLK_EN); end
        tests++; if (o_Halted !== 1'b1) begin fails++; $display("FAIL reset_halted: got %b expected 1", o_Halted); end
        tests++; if (o_Break_Hit !== 1'b0) begin fails++; $display("FAIL reset_break_hit: got %b expected 0", o_Break_Hit); end
        tests++; if (o_Cycle_Cnt !== 32'd0) begin fails++; $display("FAIL reset_cycle_cnt: got %0d expected 0", o_Cycle_Cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        next_cycle();
        tests++; if (o_CLK_EN !== 1'b0) begin fails++; $display("FAIL run_first_edge: got %b expected 0", o_CLK_EN); end
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            tests++; if (o_CLK_EN !== 1'b1) begin fails++; $display("FAIL run_en[%0d]: got %b expected 1", i, o_CLK_EN); end
        end
        next_cycle();
        tests++; if (o_Cycle_Cnt !== 32'd10) begin fails++; $display("FAIL run_cycle_cnt: got %0d expected 10", o_Cycle_Cnt); end
        tests++; if (o_Halted !== 1'b0) begin fails++; $display("FAIL run_halted: got %b expected 0", o_Halted); end
    endtask

    task automatic test_div();
        bit found = 1'b0;
        logic exp;
        i_Div = DIV_W'(3);
        i_Mode = M_DIV;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            if (o_CLK_EN === 1'b1) begin found = 1'b1; break; end
        end
        tests++; if (!found) begin fails++; $display("FAIL div_first_pulse: got none expected pulse within 20 cycles"); end
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            exp = (i % 4 == 0);
            tests++; if (o_CLK_EN !== exp) begin fails++; $display("FAIL div3_pattern[%0d]: got %b expected %b", i, o_CLK_EN, exp); end
        end
        next_cycle();
        tests++; if (o_CLK_EN !== 1'b0) begin fails++; $display("FAIL div3_after_pulse: got %b expected 0", o_CLK_EN); end
        i_Div = '0;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            tests++; if (o_CLK_EN !== 1'b1) begin fails++; $display("FAIL div0_every_cycle[%0d]: got %b expected 1", i, o_CLK_EN); end
        end
    endtask

    task automatic test_step();
        logic [31:0] cnt0;
        logic exp;
        int extra = 0;
        i_Mode = M_STEP;
        repeat (4) next_cycle();
        tests++; if (o_CLK_EN !== 1'b0) begin fails++; $display("FAIL step_idle_en: got %b expected 0", o_CLK_EN); end
        tests++; if (o_Halted !== 1'b1) begin fails++; $display("FAIL step_idle_halted: got %b expected 1", o_Halted); end
        cnt0 = o_Cycle_Cnt;
        i_Step = 1'b1;
        for (int k = 1; k <= int'(SYNC) + 2; k++) begin
            next_cycle();
            exp = (k == int'(SYNC) + 2);
            tests++; if (o_CLK_EN !== exp) begin fails++; $display("FAIL step_latency_edge%0d: got %b expected %b", k, o_CLK_EN, exp); end
        end
        for (int i = 0; i < 46; i++) begin
            next_cycle();
            if (o_CLK_EN === 1'b1) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL step_held_extra: got %0d expected 0", extra); end
        i_Step = 1'b0;
        repeat (4) next_cycle();
        tests++; if (o_Cycle_Cnt !== cnt0 + 32'd1) begin fails++; $display("FAIL step_cycle_cnt: got %0d expected %0d", o_Cycle_Cnt, cnt0 + 32'd1); end
    endtask

    // Stimulus only: press step, optionally press again mid-burst, and measure the enable run.
    task automatic run_burst(input int len, input bit second, output int cnt, output int span,
                             output logic halted_mid);
        int first = -1;
        int last  = -1;
        cnt = 0;
        halted_mid = 1'bx;
        i_Burst_Len = CNT_W'(len);
        i_Step = 1'b1;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            if (i == 2) i_Step = 1'b0;
            if (o_CLK_EN === 1'b1) begin
                if (first < 0) begin first = i; halted_mid = o_Halted; end
                last = i;
                cnt++;
            end
            if (second && first >= 0 && i == first + 1) i_Step = 1'b1;
            if (second && first >= 0 && i == first + 3) i_Step = 1'b0;
        end
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    task automatic test_burst();
        int cnt;
        int span;
        logic hm;
        bit found = 1'b0;
        i_Mode = M_BURST;
        repeat (3) next_cycle();
        run_burst(5, 1'b0, cnt, span, hm);
        tests++; if (cnt !== 5) begin fails++; $display("FAIL burst5_count: got %0d expected 5", cnt); end
        tests++; if (span !== 5) begin fails++; $display("FAIL burst5_consecutive: got span %0d expected 5", span); end
        tests++; if (hm !== 1'b0) begin fails++; $display("FAIL burst5_halted_during: got %b expected 0", hm); end
        tests++; if (o_Halted !== 1'b1) begin fails++; $display("FAIL burst5_halted_after: got %b expected 1", o_Halted); end
        run_burst(8, 1'b1, cnt, span, hm);
        tests++; if (cnt !== 8) begin fails++; $display("FAIL burst8_second_step_ignored: got %0d expected 8", cnt); end
        run_burst(0, 1'b0, cnt, span, hm);
        tests++; if (cnt !== 0) begin fails++; $display("FAIL burst0_count: got %0d expected 0", cnt); end
        tests++; if (o_Halted !== 1'b1) begin fails++; $display("FAIL burst0_halted: got %b expected 1", o_Halted); end
        // Reset asserted in the middle of a long burst.
        i_Burst_Len = CNT_W'(20);
        i_Step = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if (i == 2) i_Step = 1'b0;
            if (o_CLK_EN === 1'b1) begin found = 1'b1; break; end
        end
        tests++; if (!found) begin fails++; $display("FAIL burst20_start: got none expected enable within 10 cycles"); end
        next_cycle();
        i_Step = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++; if (o_CLK_EN !== 1'b0) begin fails++; $display("FAIL midburst_reset_en: got %b expected 0", o_CLK_EN); end
        tests++; if (o_Halted !== 1'b1) begin fails++; $display("FAIL midburst_reset_halted: got %b expected 1", o_Halted); end
        tests++; if (o_Break_Hit !== 1'b0) begin fails++; $display("FAIL midburst_reset_break_hit: got %b expected 0", o_Break_Hit); end
        tests++; if (o_Cycle_Cnt !== 32'd0) begin fails++; $display("FAIL midburst_reset_cycle_cnt: got %0d expected 0", o_Cycle_Cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if (o_CLK_EN === 1'b1) cnt++;
        end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL midburst_reset_no_resume: got %0d expected 0", cnt); end
    endtask

    task automatic test_breakpoint();
        rst_n = 1'b0; i_Mode = M_RUN; i_Div = '0; i_Step = 1'b0; i_Burst_Len = '0;
        i_PC = '0; i_Break_Addr = PC_W'(7); i_Break_Valid = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pc_track = 1'b1;
`ifdef HACK_DEBUG_BREAKPOINT_EN
        begin
            bit reached = 1'b0;
            for (int i = 0; i < 30; i++) begin
                next_cycle();
                if (i_PC == PC_W'(7)) begin reached = 1'b1; break; end
            end
            tests++; if (!reached) begin fails++; $display("FAIL bp_reach_pc7: got pc %0d expected 7", i_PC); end
            tests++; if (o_CLK_EN !== 1'b0) begin fails++; $display("FAIL bp_gate_same_cycle: got %b expected 0", o_CLK_EN); end
            next_cycle();
            tests++; if (o_Break_Hit !== 1'b1) begin fails++; $display("FAIL bp_break_hit: got %b expected 1", o_Break_Hit); end
            tests++; if (o_Halted !== 1'b1) begin fails++; $display("FAIL bp_halted: got %b expected 1", o_Halted); end
            repeat (5) next_cycle();
            tests++; if (i_PC !== PC_W'(7)) begin fails++; $display("FAIL bp_parked_pc: got %0d expected 7", i_PC); end
            i_Step = 1'b1;
            repeat (3) next_cycle();
            i_Step = 1'b0;
            repeat (12) next_cycle();
            tests++; if (i_PC <= PC_W'(8)) begin fails++; $display("FAIL bp_resume_pc: got %0d expected above 8", i_PC); end
            tests++; if (o_Break_Hit !== 1'b0) begin fails++; $display("FAIL bp_resume_break_hit: got %b expected 0", o_Break_Hit); end
            tests++; if (o_Halted !== 1'b0) begin fails++; $display("FAIL bp_resume_halted: got %b expected 0", o_Halted); end
        end
`else
        begin
            bit saw_hit = 1'b0;
            for (int i = 0; i < 20; i++) begin
                next_cycle();
                if (o_Break_Hit === 1'b1) saw_hit = 1'b1;
            end
            tests++; if (i_PC !== PC_W'(18)) begin fails++; $display("FAIL nobp_pc_runs_past: got %0d expected 18", i_PC); end
            tests++; if (saw_hit !== 1'b0) begin fails++; $display("FAIL nobp_break_hit: got %b expected 0", saw_hit); end
            tests++; if (o_Halted !== 1'b0) begin fails++; $display("FAIL nobp_halted: got %b expected 0", o_Halted); end
        end
`endif
        pc_track = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; i_Mode = M_RUN; i_Div = '0; i_Step = 1'b0; i_Burst_Len = '0;
        i_PC = '0; i_Break_Addr = '0; i_Break_Valid = 1'b0;
        test_reset();
        test_run();
        test_div();
        test_step();
        test_burst();
        test_breakpoint();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hack_debug_clk_ctrl.md
# hack_debug_clk_ctrl

Parametrised debug clock-enable controller for the Hack computer. It generates the single-cycle clock-enable that gates CPU/memory state updates, replacing the constant-high debug enable with free-run, divided, single-step, N-cycle burst and PC-breakpoint modes. It sits between the board clock/buttons and the Hack computer's debug clock-enable input. It also counts executed (enabled) cycles for on-board LED/debug readout.

## Interface
- DIV_W, 24: width of divider reload value.
- CNT_W, 16: width of burst length.
- PC_W, 15: width of Hack program counter.
- SYNC_STAGES, 2: synchroniser depth for i_Step (min 2).
- i_CLK  in  1  system clock; all logic on rising edge.
- i_RESET_n  in  1  asynchronous, active-low reset.
- i_Mode  in  2  00 RUN, 01 DIV, 10 STEP, 11 BURST; synchronous to i_CLK.
- i_Div  in  DIV_W  DIV mode: one enable every i_Div+1 cycles.
- i_Step  in  1  raw active-high button, asynchronous.
- i_Burst_Len  in  CNT_W  enabled cycles per BURST trigger; sampled on trigger.
- i_PC  in  PC_W  current CPU PC.
- i_Break_Addr  in  PC_W  breakpoint address.
- i_Break_Valid  in  1  breakpoint armed.
- o_CLK_EN  out  1  CPU clock-enable.
- o_Halted  out  1  registered; 1 when no enable will issue without a step.
- o_Break_Hit  out  1  registered; 1 while parked at breakpoint.
- o_Cycle_Cnt  out  32  count of cycles with o_CLK_EN=1.

## Operation
- Step path: SYNC_STAGES flops, then rising-edge detect -> 1-cycle pulse w_step. Button held = one pulse.
- States: IDLE, RUN, BURST, BREAK. Internal r_en (registered) drives o_CLK_EN = r_en & ~w_hit.
- w_hit = i_Break_Valid & (i_PC == i_Break_Addr) & ~r_skip & state in {RUN, BURST}.
- RUN mode: state RUN, r_en=1 every cycle.
- DIV mode: state RUN, counter 0..i_Div; r_en=1 when counter >= i_Div, counter then clears. i_Div=0 -> every cycle; lowering i_Div below counter fires next cycle.
- STEP mode: IDLE; w_step -> exactly one enabled cycle, back to IDLE.
- BURST mode: IDLE; w_step loads i_Burst_Len into down-counter, state BURST, one enable per cycle until counter hits 0, then IDLE. i_Burst_Len=0 -> no enable, stay IDLE. w_step during BURST ignored.
- Breakpoint: any cycle w_hit=1 -> o_CLK_EN forced 0 that cycle (instruction at i_Break_Addr not executed), state BREAK, o_Break_Hit=1. In BREAK: w_step -> r_skip=1, return to RUN (RUN/DIV) or resume BURST with remaining count; r_skip clears after first enabled cycle.
- Mode change: takes effect next cycle; aborts burst, clears divider, clears BREAK and r_skip.
- o_Cycle_Cnt increments on every o_CLK_EN=1 cycle, wraps 2^32-1 -> 0.
- o_Halted=1 in IDLE and BREAK, 0 in RUN/BURST.

## Timing
- Reset (asserted any time, mid-burst included): o_CLK_EN=0, o_Halted=1, o_Break_Hit=0, o_Cycle_Cnt=0, state IDLE, counters 0, synchroniser cleared.
- After reset release in RUN: first o_CLK_EN=1 on second rising edge.
- Step latency: i_Step high sampled -> o_CLK_EN=1 exactly SYNC_STAGES+2 edges later.
- Breakpoint latency: 0 (combinational gate on same cycle); o_Break_Hit rises next edge.
- BURST of N: exactly N consecutive enabled cycles absent breakpoint.

## Configuration
- HACK_DEBUG_BREAKPOINT_EN defined: breakpoint compare, BREAK state and r_skip as above.
- Undefined: w_hit constant 0, no comparator; i_PC, i_Break_Addr, i_Break_Valid ignored; o_Break_Hit tied 0; BREAK state unreachable.

## Test plan
- Reset release, i_Mode=00 -> o_CLK_EN 0,0 then 1 continuously; o_Cycle_Cnt=10 after 10 enabled cycles.
- i_Mode=01, i_Div=3 -> o_CLK_EN pulses every 4th cycle; change i_Div to 0 mid-count -> pulse next cycle then every cycle.
- i_Mode=10, hold i_Step high 50 cycles -> exactly one o_CLK_EN pulse, SYNC_STAGES+2 edges after press.
- i_Mode=11, i_Burst_Len=5, step -> 5 enables, o_Halted 0->1; second step mid-burst ignored; i_Burst_Len=0 -> none; reset mid-burst -> all outputs reset values.
- Macro on, RUN, i_Break_Addr=7, PC counting -> o_CLK_EN=0 when i_PC=7, o_Break_Hit=1; step -> PC advances past 7, running resumes.
- Macro off, same stimulus -> no halt at PC 7, o_Break_Hit stays 0.
